// File: rtl/hdc_msg_streamer_if.sv
// -----------------------------------------------------------------------------
// hdc_msg_streamer_if
//
// Purpose
//   Bundles every signal that hdc_msg_streamer exchanges with its surroundings
//   except clk and reset. The three channels are the message load port, the
//   char stream to the encoder and the classifier result strobe. The interface
//   also carries the scoring outputs and a debug view of the FSM state.
//
// Modports
//   master : the streamer itself (drives load_ready, the char stream, the
//            score flags, the counters and fsm_state)
//   slave  : the environment (host/loader, encoder, classifier)
//
// Handshake rules (valid/ready)
//   A transfer happens on a rising edge where valid && ready are both high.
//   While valid is high and ready is low, the sender holds its payload
//   (data/last) stable. valid is never withdrawn before the transfer.
//   The load channel offers load_valid. Only the streamer's load_ready
//   (high in IDLE only) completes it.
//   The result channel has no ready: res_valid is a one-cycle strobe that the
//   streamer takes only while it is waiting for a result.
//
// Signals
//   load_valid/load_ready   message offer / accept
//   msg                     CHAR_LENGTH*MESSAGE_LENGTH flat message, char 0 on top
//   length                  chars to stream (clamped to MESSAGE_LENGTH)
//   label                   expected tag
//   char_data/valid/ready   char stream to the encoder
//   char_last               marks the final char of the message
//   res_valid/res_label     classifier result strobe and value
//   cmp_done                one-cycle pulse when a message is scored
//   cmp_match               result equalled the tag (valid with cmp_done)
//   cmp_inconclusive        result all-ones, empty message or watchdog expiry
//   total_cnt/correct_cnt   saturating score counters
//   fsm_state               current FSM state (0 IDLE,1 STREAM,2 WAIT_RES,3 REPORT)
// -----------------------------------------------------------------------------
interface hdc_msg_streamer_if #(
   parameter int MESSAGE_LENGTH = 160,
   parameter int CHAR_LENGTH    = 8,
   parameter int LABEL_WIDTH    = 2,
   parameter int CNT_WIDTH      = 16
);
   logic                                  load_valid;
   logic                                  load_ready;
   logic [CHAR_LENGTH*MESSAGE_LENGTH-1:0] msg;
   logic [7:0]                            length;
   logic [LABEL_WIDTH-1:0]                label;

   logic [CHAR_LENGTH-1:0]                char_data;
   logic                                  char_valid;
   logic                                  char_ready;
   logic                                  char_last;

   logic                                  res_valid;
   logic [LABEL_WIDTH-1:0]                res_label;

   logic                                  cmp_done;
   logic                                  cmp_match;
   logic                                  cmp_inconclusive;
   logic [CNT_WIDTH-1:0]                  total_cnt;
   logic [CNT_WIDTH-1:0]                  correct_cnt;

   logic [1:0]                            fsm_state;

   modport master (
      input  load_valid, msg, length, label,
      input  char_ready,
      input  res_valid, res_label,
      output load_ready,
      output char_data, char_valid, char_last,
      output cmp_done, cmp_match, cmp_inconclusive,
      output total_cnt, correct_cnt,
      output fsm_state
   );

   modport slave (
      output load_valid, msg, length, label,
      output char_ready,
      output res_valid, res_label,
      input  load_ready,
      input  char_data, char_valid, char_last,
      input  cmp_done, cmp_match, cmp_inconclusive,
      input  total_cnt, correct_cnt,
      input  fsm_state
   );
endinterface

// File: rtl/hdc_msg_streamer.sv
// -----------------------------------------------------------------------------
// hdc_msg_streamer
//
// Purpose
//   Drives the HDC spam/ham classifier. It accepts one flat message word
//   together with its char length and expected tag. It then streams the chars
//   to the encoder one per handshake and waits for the classifier result. It
//   scores that result against the tag and keeps running total/correct
//   counts, so the hardware can report accuracy on its own.
//
// Ports
//   clk    : clock, all logic on the rising edge
//   reset  : synchronous, active-high; clears the FSM, the flags and the counters
//   bus    : hdc_msg_streamer_if.master (load, char stream, result, score,
//            counters, fsm_state debug view)
//
// Configuration
//   STREAM_TIMEOUT_EN : when defined, a watchdog limits WAIT_RES to
//                       TIMEOUT_CYCLES cycles. On expiry the message is scored
//                       as inconclusive. When undefined, WAIT_RES waits
//                       indefinitely.
//
// FSM
//   IDLE -> STREAM -> WAIT_RES -> REPORT -> IDLE
//   IDLE -> REPORT directly for an empty message (scored inconclusive).
//   The FSM is written as three processes: state register, next-state logic
//   and output logic.
// -----------------------------------------------------------------------------
module hdc_msg_streamer #(
   parameter int MESSAGE_LENGTH = 160,
   parameter int CHAR_LENGTH    = 8,
   parameter int LABEL_WIDTH    = 2,
   parameter int CNT_WIDTH      = 16,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                clk,
   input  logic                reset,
   hdc_msg_streamer_if.master  bus
);

   localparam int MSG_W = CHAR_LENGTH * MESSAGE_LENGTH;

   // length is 8 bits wide, so the clamp value itself must fit in 8 bits.
   localparam int         MAX_LEN  = (MESSAGE_LENGTH > 255) ? 255 : MESSAGE_LENGTH;
   localparam logic [7:0] MAX_LEN8 = MAX_LEN[7:0];

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_STREAM   = 2'd1,
      S_WAIT_RES = 2'd2,
      S_REPORT   = 2'd3
   } state_t;

   state_t                 state_q;
   state_t                 state_d;

   // Message datapath. The captured message is held in a shift register. The
   // char on the wire is always the top CHAR_LENGTH bits, and each handshake
   // shifts the next char up. This yields the same char sequence as indexing
   // msg by idx, without a MESSAGE_LENGTH-wide read mux.
   logic [MSG_W-1:0]       shift_q;
   logic [LABEL_WIDTH-1:0] label_q;
   logic [7:0]             len_q;
   logic [7:0]             idx_q;

   // Score flags and counters.
   logic                   match_q;
   logic                   incon_q;
   logic [CNT_WIDTH-1:0]   total_q;
   logic [CNT_WIDTH-1:0]   correct_q;

   logic [7:0]             len_cap;
   logic                   load_fire;
   logic                   char_fire;
   logic                   is_last;
   logic                   timeout;

   // Scoring decision, made on the cycle that enters REPORT. Both the flags
   // and the counters are therefore already updated while cmp_done is high.
   logic                   score_now;
   logic                   score_match;
   logic                   score_incon;

   assign len_cap   = (bus.length > MAX_LEN8) ? MAX_LEN8 : bus.length;
   assign load_fire = (state_q == S_IDLE)   && bus.load_valid;
   assign char_fire = (state_q == S_STREAM) && bus.char_ready;
   assign is_last   = (idx_q == (len_q - 8'd1));

   // ---------------------------------------------------------------------------
   // Result watchdog
   // ---------------------------------------------------------------------------
`ifdef STREAM_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [TO_W-1:0] wait_cnt_q;

   // wait_cnt_q is the number of WAIT_RES cycles already spent. On the
   // TIMEOUT_CYCLES-th cycle without a result the FSM leaves for REPORT, so
   // cmp_done appears TIMEOUT_CYCLES cycles after WAIT_RES was entered.
   always_ff @(posedge clk) begin
      if (reset || (state_q != S_WAIT_RES)) begin
         wait_cnt_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_q + TO_W'(1);
      end
   end

   assign timeout = (state_q == S_WAIT_RES) && (wait_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (bus.load_valid) begin
               state_d = (len_cap == 8'd0) ? S_REPORT : S_STREAM;
            end
         end
         S_STREAM: begin
            if (bus.char_ready && is_last) begin
               state_d = S_WAIT_RES;
            end
         end
         S_WAIT_RES: begin
            if (bus.res_valid || timeout) begin
               state_d = S_REPORT;
            end
         end
         S_REPORT: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      bus.load_ready = 1'b0;
      bus.char_valid = 1'b0;
      bus.char_last  = 1'b0;
      bus.char_data  = '0;
      bus.cmp_done   = 1'b0;
      case (state_q)
         S_IDLE: begin
            bus.load_ready = 1'b1;
         end
         S_STREAM: begin
            bus.char_valid = 1'b1;
            bus.char_last  = is_last;
            bus.char_data  = shift_q[MSG_W-1 -: CHAR_LENGTH];
         end
         S_REPORT: begin
            bus.cmp_done = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign bus.cmp_match        = match_q;
   assign bus.cmp_inconclusive = incon_q;
   assign bus.total_cnt        = total_q;
   assign bus.correct_cnt      = correct_q;
   assign bus.fsm_state        = state_q;

   // ---------------------------------------------------------------------------
   // Scoring decision
   // ---------------------------------------------------------------------------
   // Sources of a score:
   //   - an empty message accepted in IDLE (always inconclusive)
   //   - a result strobe while waiting (inconclusive when the result is all-ones)
   //   - watchdog expiry while waiting (inconclusive)
   // A result strobe takes priority over a watchdog expiry in the same cycle.
   always_comb begin
      score_now   = 1'b0;
      score_match = 1'b0;
      score_incon = 1'b0;
      if (load_fire && (len_cap == 8'd0)) begin
         score_now   = 1'b1;
         score_incon = 1'b1;
      end else if (state_q == S_WAIT_RES) begin
         if (bus.res_valid) begin
            score_now   = 1'b1;
            score_incon = &bus.res_label;
            score_match = !(&bus.res_label) && (bus.res_label == label_q);
         end else if (timeout) begin
            score_now   = 1'b1;
            score_incon = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         shift_q   <= '0;
         label_q   <= '0;
         len_q     <= '0;
         idx_q     <= '0;
         match_q   <= 1'b0;
         incon_q   <= 1'b0;
         total_q   <= '0;
         correct_q <= '0;
      end else begin
         if (load_fire) begin
            shift_q <= bus.msg;
            label_q <= bus.label;
            len_q   <= len_cap;
            idx_q   <= '0;
         end else if (char_fire) begin
            shift_q <= {shift_q[MSG_W-CHAR_LENGTH-1:0], {CHAR_LENGTH{1'b0}}};
            idx_q   <= idx_q + 8'd1;
         end

         // The flags only change here, so they hold until the next REPORT.
         if (score_now) begin
            match_q <= score_match;
            incon_q <= score_incon;
            if (total_q != {CNT_WIDTH{1'b1}}) begin
               total_q <= total_q + CNT_WIDTH'(1);
            end
            if (score_match && (correct_q != {CNT_WIDTH{1'b1}})) begin
               correct_q <= correct_q + CNT_WIDTH'(1);
            end
         end
      end
   end

endmodule
